// File: rtl/video_timing_gen_if.sv
// Raster timing bundle between the timing generator and the renderers.
// The generator side is the master; renderers and monitors use slave.
interface video_timing_gen_if;
    logic       mode;
    logic [8:0] irq_line;
    logic [9:0] hpos;
    logic       hsync;
    logic       hblank;
    logic       hlast;
    logic [9:0] vline;
    logic [8:0] vpos;
    logic       vsync;
    logic       vblank;
    logic       vnext;
    logic       blank;
    logic       frame_start;
    logic       line_irq;
    logic [7:0] frame_cnt;
    logic       mode_active;

    modport master (
        input  mode, irq_line,
        output hpos, hsync, hblank, hlast,
        output vline, vpos, vsync, vblank, vnext,
        output blank, frame_start, line_irq,
        output frame_cnt, mode_active
    );

    modport slave (
        output mode, irq_line,
        input  hpos, hsync, hblank, hlast,
        input  vline, vpos, vsync, vblank, vnext,
        input  blank, frame_start, line_irq,
        input  frame_cnt, mode_active
    );
endinterface

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: two horizontal modes, optional
// line doubling, frame pulse, raster line interrupt and frame counter.
module video_timing_gen #(
    parameter int unsigned H0_ACTIVE     = 704,
    parameter int unsigned H0_SYNC_START = 746,
    parameter int unsigned H0_SYNC_END   = 854,
    parameter int unsigned H0_TOTAL      = 910,
    parameter int unsigned H1_ACTIVE     = 640,
    parameter int unsigned H1_SYNC_START = 656,
    parameter int unsigned H1_SYNC_END   = 752,
    parameter int unsigned H1_TOTAL      = 800,
    parameter int unsigned V_ACTIVE      = 480,
    parameter int unsigned V_SYNC_START  = 490,
    parameter int unsigned V_SYNC_END    = 492,
    parameter int unsigned V_TOTAL       = 525,
    parameter int unsigned VSCALE_LOG2   = 1,
    parameter int unsigned HSYNC_POL     = 0,
    parameter int unsigned VSYNC_POL     = 0
) (
    input  logic clk,
    input  logic reset_n,
    video_timing_gen_if.master bus
);

    localparam logic HS_ON = (HSYNC_POL != 0);
    localparam logic VS_ON = (VSYNC_POL != 0);

    logic [9:0]  r_hcnt;
    logic [9:0]  r_vcnt;
    logic [7:0]  r_frame_cnt;
    logic        r_mode;

    // 11-bit views so a SYNC_END or TOTAL of 1024 still compares correctly
    logic [10:0] w_hcnt_x;
    logic [10:0] w_vcnt_x;
    logic [10:0] w_h_active;
    logic [10:0] w_h_sync_start;
    logic [10:0] w_h_sync_end;
    logic [10:0] w_h_last;
    logic        w_hlast;
    logic        w_vlast;
    logic        w_hsync_act;
    logic        w_vsync_act;
    logic        w_hblank;
    logic        w_vblank;
    logic [8:0]  w_vpos;
    logic        w_vnext;
    logic        w_frame_start;
    logic        w_line_irq;

    assign w_hcnt_x = {1'b0, r_hcnt};
    assign w_vcnt_x = {1'b0, r_vcnt};

    assign w_h_active     = r_mode ? 11'(H1_ACTIVE)     : 11'(H0_ACTIVE);
    assign w_h_sync_start = r_mode ? 11'(H1_SYNC_START) : 11'(H0_SYNC_START);
    assign w_h_sync_end   = r_mode ? 11'(H1_SYNC_END)   : 11'(H0_SYNC_END);
    assign w_h_last       = r_mode ? 11'(H1_TOTAL - 1)  : 11'(H0_TOTAL - 1);

    assign w_hlast = (w_hcnt_x == w_h_last);
    assign w_vlast = (w_vcnt_x == 11'(V_TOTAL - 1));

    assign w_hsync_act = (w_hcnt_x >= w_h_sync_start) &&
                         (w_hcnt_x <  w_h_sync_end);
    assign w_vsync_act = (w_vcnt_x >= 11'(V_SYNC_START)) &&
                         (w_vcnt_x <  11'(V_SYNC_END));

    assign w_hblank = (w_hcnt_x >= w_h_active);
    assign w_vblank = (w_vcnt_x >= 11'(V_ACTIVE));

    assign w_vpos  = 9'(r_vcnt >> VSCALE_LOG2);
    // a scaled line ends on the odd raw line when doubling
    assign w_vnext = w_hlast && ((VSCALE_LOG2 == 0) || r_vcnt[0]);

    assign w_frame_start = w_hlast && w_vlast;
    assign w_line_irq    = w_vnext && (w_vpos == bus.irq_line);

    assign bus.hpos        = r_hcnt;
    assign bus.hsync       = w_hsync_act ? HS_ON : ~HS_ON;
    assign bus.hblank      = w_hblank;
    assign bus.hlast       = w_hlast;
    assign bus.vline       = r_vcnt;
    assign bus.vpos        = w_vpos;
    assign bus.vsync       = w_vsync_act ? VS_ON : ~VS_ON;
    assign bus.vblank      = w_vblank;
    assign bus.vnext       = w_vnext;
    assign bus.blank       = w_hblank | w_vblank;
    assign bus.frame_start = w_frame_start;
    assign bus.line_irq    = w_line_irq;
    assign bus.frame_cnt   = r_frame_cnt;
    assign bus.mode_active = r_mode;

    // Pixel/line counters; mode and frame count only move at frame end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hcnt      <= '0;
            r_vcnt      <= '0;
            r_frame_cnt <= '0;
            r_mode      <= 1'b0;
        end else begin
            if (w_hlast) begin
                r_hcnt <= '0;
                r_vcnt <= w_vlast ? '0 : r_vcnt + 10'd1;
            end else begin
                r_hcnt <= r_hcnt + 10'd1;
            end
            if (w_frame_start) begin
                r_mode      <= bus.mode;
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
        end
    end

endmodule
